gauss5_window_ctrl: RTL

- Sequences the 5x5 Gaussian window datapath for one RGB888 pixel stream per frame.
- Tracks row and column of every incoming pixel and drives the enables of the four external line-buffer FIFOs that feed din1..din5.
- Generates the valid_in beat for the valid-gated 5x5 matrix, tags each beat so the delayed matrix output can be marked valid, interior or border, and drains the matrix pipeline at end of frame.

---
 rtl/gauss5_window_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gauss5_window_ctrl.sv
// Sequencer for a 5x5 Gaussian window: pixel row/column tracking, line-buffer enables,
// matrix valid_in beats, result tagging and end-of-frame drain.
module gauss5_window_ctrl #(
    parameter int PIC_WIDTH  = 640,
    parameter int PIC_HEIGHT = 480,
    parameter int MATRIX_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic        sof,
    input  logic        clr_err,
    output logic        lb_wr_en,
    output logic [3:0]  lb_rd_en,
    output logic        win_valid,
    output logic        flush,
    output logic        out_valid,
    output logic        out_border,
    output logic [10:0] out_row,
    output logic [10:0] out_col,
    output logic        eof,
    output logic        busy,
    output logic        err_sof,
    output logic        err_drop
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    typedef struct packed {
        logic        v;
        logic        border;
        logic [10:0] row;
        logic [10:0] col;
    } tag_t;

    localparam int          DCW        = (MATRIX_LAT > 2) ? $clog2(MATRIX_LAT - 1) : 1;
    localparam logic [10:0] LAST_COL   = 11'(PIC_WIDTH - 1);
    localparam logic [10:0] LAST_ROW   = 11'(PIC_HEIGHT - 1);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(MATRIX_LAT - 2);

    state_t          state;
    logic [10:0]     col, row;
    logic [DCW-1:0]  drain_cnt;
    tag_t            pipe [1:MATRIX_LAT-1];

    logic        in_frame, acc, abort, drop, restart, real_beat, drain_beat;
    logic [10:0] cur_col, cur_row;
    tag_t        new_tag;

    // A restarting pixel (IDLE accept or mid-frame sof) is always (0,0), whatever the counters hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        new_tag    = '0;
        in_frame   = (state == FILL) || (state == RUN);
        abort      = pix_valid && sof && in_frame;
        acc        = pix_valid && (in_frame || ((state == IDLE) && sof));
        drop       = pix_valid && !acc;
        restart    = abort || (state == IDLE);
        cur_col    = restart ? 11'd0 : col;
        cur_row    = restart ? 11'd0 : row;
        real_beat  = acc && (cur_row >= 11'd4);
        drain_beat = (state == DRAIN);
        if (real_beat) begin
            new_tag = '{v: 1'b1, border: (cur_col < 11'd4), row: cur_row - 11'd2, col: cur_col - 11'd2};
        end
    end

    always_comb begin
        lb_rd_en = '0;
        for (int k = 0; k < 4; k++) begin
            lb_rd_en[k] = acc && (cur_row > 11'(k));
        end
    end

    assign lb_wr_en  = acc;
    assign win_valid = real_beat || drain_beat;
    assign flush     = drain_beat;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            eof       <= 1'b0;
            err_sof   <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            eof <= 1'b0;
            if (acc) begin
                if (cur_col == LAST_COL) begin
                    col <= '0;
                    row <= (cur_row == LAST_ROW) ? 11'd0 : cur_row + 11'd1;
                end else begin
                    col <= cur_col + 11'd1;
                    row <= cur_row;
                end
            end
            case (state)
                IDLE: if (acc) state <= FILL;
                FILL: begin
                    if (!abort && acc && (cur_col == LAST_COL) && (cur_row == 11'd3)) state <= RUN;
                end
                RUN: begin
                    if (abort) begin
                        state <= FILL;
                    end else if (acc && (cur_col == LAST_COL) && (cur_row == LAST_ROW)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state <= IDLE;
                        eof   <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            err_sof  <= abort || (err_sof && !clr_err);
            err_drop <= drop || (err_drop && !clr_err);
        end
    end

    // The last stage is the output register; it only pulses for one cycle per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag pipe is reset because its valid bits gate out_valid; stale tags must never emerge.
            for (int i = 1; i < MATRIX_LAT; i++) pipe[i] <= '0;
            out_valid  <= 1'b0;
            out_border <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else if (abort) begin
            for (int i = 1; i < MATRIX_LAT; i++) pipe[i] <= '0;
            out_valid  <= 1'b0;
            out_border <= 1'b0;
        end else if (win_valid) begin
            pipe[1] <= new_tag;
            for (int i = 2; i < MATRIX_LAT; i++) pipe[i] <= pipe[i-1];
            out_valid  <= pipe[MATRIX_LAT-1].v;
            out_border <= pipe[MATRIX_LAT-1].v && pipe[MATRIX_LAT-1].border;
            out_row    <= pipe[MATRIX_LAT-1].row;
            out_col    <= pipe[MATRIX_LAT-1].col;
        end else begin
            out_valid  <= 1'b0;
            out_border <= 1'b0;
        end
    end

endmodule
